// File: rtl/dmem_if.sv
// dmem_if -- load/store request/response bundle between the EXU/LSU and a
// data-memory responder.
//
// Handshake (both channels): a transfer happens on a rising clock edge where
// valid and ready are both high. Once valid is raised, the sender holds valid
// and its payload stable until that edge. ready may be high before valid
// arrives, and ready never depends on valid within the same cycle.
//
// Signals
//   req_valid   requester -> responder  request present
//   req_ready   responder -> requester  responder can accept
//   req_wen     requester -> responder  1 = store, 0 = load
//   req_op      requester -> responder  size/extension code (see dmem_responder)
//   req_addr    requester -> responder  byte address
//   req_wdata   requester -> responder  store data, right-aligned
//   resp_valid  responder -> requester  response present
//   resp_ready  requester -> responder  requester accepts response
//   resp_rdata  responder -> requester  load result, extended to 64 bits
//   resp_err    responder -> requester  access error
interface dmem_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_wen;
    logic [2:0]  req_op;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_wen, req_op, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_wen, req_op, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder -- data-memory responder at the slave end of the EXU
// load/store path. Accepts one request at a time, waits LATENCY cycles, then
// performs a byte/half/word/double store or a sign/zero-extended load on an
// internal 64-bit-wide RAM and returns the result with an error flag.
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   bus        dmem_if.slave: request and response channels
//   dbg_state  current FSM state (0 IDLE, 1 WAIT, 2 RESP)
//
// req_op: 000 B, 001 H, 010 W, 011 D (signed loads / stores),
//         100 BU, 101 HU, 110 WU (loads only), 111 illegal.
// Errors (no RAM write, rdata 0): address outside the RAM window, natural
// misalignment, op 111, or a store with an unsigned-load op.
module dmem_responder #(
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter int unsigned LATENCY    = 2,
    parameter logic [63:0] BASE_ADDR  = 64'h8000_0000
) (
    input  logic       clk,
    input  logic       rst,
    dmem_if.slave      bus,
    output logic [1:0] dbg_state
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam logic [63:0] SPAN  = 64'(DEPTH) << 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic        lat_wen;
    logic [2:0]  lat_op;
    logic [63:0] lat_addr;
    logic [63:0] lat_wdata;
    logic        req_ready_q;
    logic        resp_valid_q;
    logic [63:0] resp_rdata_q;
    logic        resp_err_q;

    logic [63:0] mem [DEPTH];

    logic [63:0]           off;
    logic [DEPTH_LOG2-1:0] word_idx;
    logic [2:0]            lane;
    logic                  out_of_range;
    logic                  misaligned;
    logic                  illegal;
    logic                  acc_err;
    logic [7:0]            size_mask;
    logic [7:0]            byte_mask;
    logic [63:0]           rd_shift;
    logic [63:0]           wr_shift;
    logic [63:0]           ld_val;
    logic                  access_now;
    logic                  mem_we;

    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_err   = resp_err_q;
    assign dbg_state      = state;

    // Decode works on the latched request so the requester may change its
    // bus signals as soon as the request handshake has happened.
    always_comb begin
        off          = lat_addr - BASE_ADDR;
        word_idx     = off[DEPTH_LOG2+2:3];
        lane         = lat_addr[2:0];
        out_of_range = (lat_addr < BASE_ADDR) || (off >= SPAN);

        size_mask  = 8'h01;
        misaligned = 1'b0;
        case (lat_op[1:0])
            2'd0: begin size_mask = 8'h01; misaligned = 1'b0;                 end
            2'd1: begin size_mask = 8'h03; misaligned = lat_addr[0]   != 1'b0;  end
            2'd2: begin size_mask = 8'h0F; misaligned = lat_addr[1:0] != 2'b00; end
            default: begin size_mask = 8'hFF; misaligned = lat_addr[2:0] != 3'b000; end
        endcase

        illegal = (lat_op == 3'b111) || (lat_wen && lat_op[2]);
        acc_err = out_of_range || misaligned || illegal;

        // Alignment is checked, so the shifted mask never runs off the word.
        byte_mask = size_mask << lane;
        rd_shift  = mem[word_idx] >> {lane, 3'b000};
        wr_shift  = lat_wdata << {lane, 3'b000};

        case (lat_op)
            3'b000:  ld_val = {{56{rd_shift[7]}},  rd_shift[7:0]};
            3'b001:  ld_val = {{48{rd_shift[15]}}, rd_shift[15:0]};
            3'b010:  ld_val = {{32{rd_shift[31]}}, rd_shift[31:0]};
            3'b011:  ld_val = rd_shift;
            3'b100:  ld_val = {56'd0, rd_shift[7:0]};
            3'b101:  ld_val = {48'd0, rd_shift[15:0]};
            3'b110:  ld_val = {32'd0, rd_shift[31:0]};
            default: ld_val = 64'd0;
        endcase

        access_now = (state == ST_WAIT) && (cnt == 4'd0);
        mem_we     = access_now && lat_wen && !acc_err;
    end

    // RAM is not reset. The write is gated by the async-reset FSM state, so a
    // store abandoned by reset before its access edge never lands.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 8; b++) begin
                if (byte_mask[b]) begin
                    mem[word_idx][8*b +: 8] <= wr_shift[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            cnt          <= 4'd0;
            lat_wen      <= 1'b0;
            lat_op       <= 3'd0;
            lat_addr     <= 64'd0;
            lat_wdata    <= 64'd0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 64'd0;
            resp_err_q   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        lat_wen     <= bus.req_wen;
                        lat_op      <= bus.req_op;
                        lat_addr    <= bus.req_addr;
                        lat_wdata   <= bus.req_wdata;
                        cnt         <= 4'(LATENCY);
                        req_ready_q <= 1'b0;
                        state       <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt == 4'd0) begin
                        resp_rdata_q <= (acc_err || lat_wen) ? 64'd0 : ld_val;
                        resp_err_q   <= acc_err;
                        resp_valid_q <= 1'b1;
                        state        <= ST_RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_RESP: begin
                    if (bus.resp_ready) begin
                        resp_valid_q <= 1'b0;
                        req_ready_q  <= 1'b1;
                        state        <= ST_IDLE;
                    end
                end
                default: begin
                    state        <= ST_IDLE;
                    req_ready_q  <= 1'b1;
                    resp_valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder -- self-checking bench for dmem_responder: reset values,
// a vector table of directed loads/stores, hand-written hold and reset
// sequences, and random traffic against a byte-array reference model.
module tb_dmem_responder;

    localparam int unsigned DEPTH_LOG2 = 10;
    localparam int unsigned LAT        = 2;
    localparam logic [63:0] BASE       = 64'h8000_0000;
    localparam longint unsigned SPAN   = 8 * 1024;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] dbg_state;

    dmem_if bus();

    dmem_responder #(
        .DEPTH_LOG2(DEPTH_LOG2),
        .LATENCY   (LAT),
        .BASE_ADDR (BASE)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [7:0]  ref_mem [8192];
    logic [63:0] exp_q[$];
    logic        exp_err_q[$];

    typedef struct {
        logic        wen;
        logic [2:0]  op;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[24];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference model: byte-addressed memory, access rules written out directly.
    function automatic void model(input logic wen, input logic [2:0] op, input logic [63:0] addr,
                                  input logic [63:0] wdata, output logic [63:0] rd, output logic err);
        int size;
        longint unsigned off;
        size = 1 << (int'(op) % 4);
        err  = 1'b0;
        rd   = 64'd0;
        if (op == 3'd7) err = 1'b1;
        if (wen && op >= 3'd4) err = 1'b1;
        if (addr < BASE || (addr - BASE) >= SPAN) err = 1'b1;
        if ((addr % 64'(size)) != 0) err = 1'b1;
        if (!err) begin
            off = addr - BASE;
            if (wen) begin
                for (int i = 0; i < size; i++) ref_mem[int'(off) + i] = wdata[8*i +: 8];
            end else begin
                for (int i = 0; i < size; i++) rd[8*i +: 8] = ref_mem[int'(off) + i];
                if (op < 3'd3 && rd[8*size-1]) begin
                    for (int i = size; i < 8; i++) rd[8*i +: 8] = 8'hFF;
                end
            end
        end
    endfunction

    // ---------------- driver ----------------
    // Issues one request, checks latency, optionally holds resp_ready low for
    // `delay` cycles (poking a competing store meanwhile), then completes the
    // response handshake.
    task automatic do_txn(input logic wen, input logic [2:0] op, input logic [63:0] addr,
                          input logic [63:0] wdata, input int delay, input bit poke,
                          output logic [63:0] rd, output logic er);
        int n;
        bit got;
        n = 0;
        while (bus.req_ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("req_ready_idle", 64'(bus.req_ready), 64'd1);
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_wen    = wen;
        bus.req_op     = op;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        bus.resp_ready = (delay == 0);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        n   = 0;
        got = bus.resp_valid;
        while (!got && n < 40) begin
            @(posedge clk); #1;
            n++;
            got = bus.resp_valid;
        end
        check("latency", 64'(n), 64'(LAT + 1));
        rd = bus.resp_rdata;
        er = bus.resp_err;
        if (delay > 0) begin
            for (int k = 0; k < delay; k++) begin
                if (poke) begin
                    @(negedge clk);
                    bus.req_valid = 1'b1;
                    bus.req_wen   = 1'b1;
                    bus.req_op    = 3'd3;
                    bus.req_addr  = BASE + 64'h8;
                    bus.req_wdata = 64'hDEAD_BEEF_DEAD_BEEF;
                end
                @(posedge clk); #1;
                check("hold_valid", 64'(bus.resp_valid), 64'd1);
                check("hold_rdata", bus.resp_rdata, rd);
                check("hold_req_ready", 64'(bus.req_ready), 64'd0);
            end
            @(negedge clk);
            bus.req_valid  = 1'b0;
            bus.resp_ready = 1'b1;
        end
        @(posedge clk); #1;
        check("post_hs_valid", 64'(bus.resp_valid), 64'd0);
        check("post_hs_ready", 64'(bus.req_ready), 64'd1);
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        while (bus.resp_valid !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("wait_valid", 64'(bus.resp_valid), 64'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"},  64'(bus.req_ready),  64'd1);
        check({tag, "_resp_valid"}, 64'(bus.resp_valid), 64'd0);
        check({tag, "_resp_rdata"}, bus.resp_rdata,      64'd0);
        check({tag, "_resp_err"},   64'(bus.resp_err),   64'd0);
        check({tag, "_state"},      64'(dbg_state),      64'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [63:0] rd, mrd, a, wd;
        logic        er, mer, w;
        logic [2:0]  op;
        int          r;

        vecs[0]  = '{1'b1, 3'd3, BASE,            64'h8877_6655_4433_2211, 64'h0, 1'b0};
        vecs[1]  = '{1'b0, 3'd3, BASE,            64'h0, 64'h8877_6655_4433_2211, 1'b0};
        vecs[2]  = '{1'b0, 3'd0, BASE + 64'h7,    64'h0, 64'hFFFF_FFFF_FFFF_FF88, 1'b0};
        vecs[3]  = '{1'b0, 3'd4, BASE + 64'h7,    64'h0, 64'h0000_0000_0000_0088, 1'b0};
        vecs[4]  = '{1'b0, 3'd1, BASE + 64'h6,    64'h0, 64'hFFFF_FFFF_FFFF_8877, 1'b0};
        vecs[5]  = '{1'b0, 3'd6, BASE + 64'h4,    64'h0, 64'h0000_0000_8877_6655, 1'b0};
        vecs[6]  = '{1'b1, 3'd0, BASE + 64'h3,    64'hAA, 64'h0, 1'b0};
        vecs[7]  = '{1'b0, 3'd3, BASE,            64'h0, 64'h8877_6655_AA33_2211, 1'b0};
        vecs[8]  = '{1'b0, 3'd2, BASE + 64'h2,    64'h0, 64'h0, 1'b1};
        vecs[9]  = '{1'b1, 3'd3, 64'h7FFF_FFF8,   64'h1, 64'h0, 1'b1};
        vecs[10] = '{1'b1, 3'd5, BASE,            64'hFFFF, 64'h0, 1'b1};
        vecs[11] = '{1'b0, 3'd3, BASE,            64'h0, 64'h8877_6655_AA33_2211, 1'b0};
        vecs[12] = '{1'b0, 3'd2, BASE,            64'h0, 64'hFFFF_FFFF_AA33_2211, 1'b0};
        vecs[13] = '{1'b0, 3'd7, BASE,            64'h0, 64'h0, 1'b1};
        vecs[14] = '{1'b1, 3'd3, BASE + 64'h1FF8, 64'h0102_0304_0506_0708, 64'h0, 1'b0};
        vecs[15] = '{1'b1, 3'd1, BASE + 64'h1FFE, 64'h1234_ABCD, 64'h0, 1'b0};
        vecs[16] = '{1'b0, 3'd3, BASE + 64'h1FF8, 64'h0, 64'hABCD_0304_0506_0708, 1'b0};
        vecs[17] = '{1'b0, 3'd5, BASE + 64'h1FFE, 64'h0, 64'h0000_0000_0000_ABCD, 1'b0};
        vecs[18] = '{1'b0, 3'd1, BASE + 64'h1FFE, 64'h0, 64'hFFFF_FFFF_FFFF_ABCD, 1'b0};
        vecs[19] = '{1'b0, 3'd0, BASE + 64'h2000, 64'h0, 64'h0, 1'b1};
        vecs[20] = '{1'b0, 3'd1, BASE + 64'h1FF9, 64'h0, 64'h0, 1'b1};
        vecs[21] = '{1'b1, 3'd2, BASE + 64'h4,    64'hCAFE_F00D_DEAD_BEEF, 64'h0, 1'b0};
        vecs[22] = '{1'b0, 3'd3, BASE,            64'h0, 64'hDEAD_BEEF_AA33_2211, 1'b0};
        vecs[23] = '{1'b0, 3'd6, BASE + 64'h4,    64'h0, 64'h0000_0000_DEAD_BEEF, 1'b0};

        // ---------------- reset ----------------
        rst            = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_wen    = 1'b0;
        bus.req_op     = 3'd0;
        bus.req_addr   = 64'd0;
        bus.req_wdata  = 64'd0;
        bus.resp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check_reset_outputs("after_reset");

        // ---------------- vector table ----------------
        for (int i = 0; i < 24; i++) begin
            model(vecs[i].wen, vecs[i].op, vecs[i].addr, vecs[i].wdata, mrd, mer);
            do_txn(vecs[i].wen, vecs[i].op, vecs[i].addr, vecs[i].wdata, i % 3, 1'b0, rd, er);
            check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            check($sformatf("vec%0d_err", i), 64'(er), 64'(vecs[i].exp_err));
        end

        // ---------------- hold in RESP, competing request ignored ----------------
        model(1'b1, 3'd3, BASE + 64'h8, 64'h0123_4567_89AB_CDEF, mrd, mer);
        do_txn(1'b1, 3'd3, BASE + 64'h8, 64'h0123_4567_89AB_CDEF, 0, 1'b0, rd, er);
        model(1'b0, 3'd3, BASE, 64'h0, mrd, mer);
        do_txn(1'b0, 3'd3, BASE, 64'h0, 5, 1'b1, rd, er);
        check("hold_ld_rdata", rd, mrd);
        model(1'b0, 3'd3, BASE + 64'h8, 64'h0, mrd, mer);
        do_txn(1'b0, 3'd3, BASE + 64'h8, 64'h0, 0, 1'b0, rd, er);
        check("poke_not_written", rd, mrd);

        // ---------------- reset during WAIT of a store ----------------
        model(1'b1, 3'd3, BASE + 64'h10, 64'h1111_2222_3333_4444, mrd, mer);
        do_txn(1'b1, 3'd3, BASE + 64'h10, 64'h1111_2222_3333_4444, 0, 1'b0, rd, er);
        model(1'b0, 3'd3, BASE, 64'h0, mrd, mer);
        do_txn(1'b0, 3'd3, BASE, 64'h0, 0, 1'b0, rd, er); // leaves nonzero rdata held
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_wen    = 1'b1;
        bus.req_op     = 3'd3;
        bus.req_addr   = BASE + 64'h10;
        bus.req_wdata  = 64'hFFFF_EEEE_DDDD_CCCC;
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        check("wait_state", 64'(dbg_state), 64'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_wait");
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model(1'b0, 3'd3, BASE + 64'h10, 64'h0, mrd, mer);
        do_txn(1'b0, 3'd3, BASE + 64'h10, 64'h0, 0, 1'b0, rd, er);
        check("rst_store_dropped", rd, mrd);

        // ---------------- reset while a response is pending ----------------
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_wen    = 1'b0;
        bus.req_op     = 3'd3;
        bus.req_addr   = BASE;
        bus.resp_ready = 1'b0;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        wait_valid();
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_resp");
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // ---------------- random traffic vs model ----------------
        for (int i = 0; i < 4; i++) begin
            wd = {$urandom, $urandom};
            model(1'b1, 3'd3, BASE + 64'(8 * i), wd, mrd, mer);
            do_txn(1'b1, 3'd3, BASE + 64'(8 * i), wd, 0, 1'b0, rd, er);
        end
        for (int i = 0; i < 80; i++) begin
            w  = 1'($urandom_range(0, 1));
            op = 3'($urandom_range(0, 7));
            r  = $urandom_range(0, 9);
            if (r == 0)      a = BASE - 64'($urandom_range(1, 16));
            else if (r == 1) a = BASE + SPAN + 64'($urandom_range(0, 16));
            else             a = BASE + 64'($urandom_range(0, 31));
            wd = {$urandom, $urandom};
            model(w, op, a, wd, mrd, mer);
            exp_q.push_back(mrd);
            exp_err_q.push_back(mer);
            do_txn(w, op, a, wd, $urandom_range(0, 2), 1'b0, rd, er);
            check($sformatf("rnd%0d_rdata", i), rd, exp_q.pop_front());
            check($sformatf("rnd%0d_err", i), 64'(er), 64'(exp_err_q.pop_front()));
        end

        // ---------------- report ----------------
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
